// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, imem req/ready handshake, one-deep stall buffer, IF/ID register
module fetch_stage #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_enable,
    input  logic               if_enable,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus4,
    output logic               ifid_valid
);

    // BOOT: one idle cycle after reset; FETCH: request outstanding;
    // HOLD: returned instruction parked while the pipe is stalled;
    // DRAIN: a redirected request is still in flight and its data is junk.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pcNext;
    logic [ADDR_W-1:0]  fa;
    logic [ADDR_W-1:0]  faNext;
    logic [INSTR_W-1:0] holdBuf;
    logic [INSTR_W-1:0] holdBufNext;
    logic [INSTR_W-1:0] instrNext;
    logic [ADDR_W-1:0]  pcPlus4Next;
    logic               validNext;

    logic               adv;
    logic [ADDR_W-1:0]  faPlus4;
    logic [ADDR_W-1:0]  target;

    assign adv     = pc_enable & if_enable;
    assign faPlus4 = fa + ADDR_W'(4);
    // Low two bits of the redirect are meaningless for word fetches.
    assign target  = branch_target & ~ADDR_W'(3);

    // The request and its address come straight from registers, never from imem_rdata.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = fa;

    // Next-state and next-register values; every path starts from "hold everything".
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        faNext      = fa;
        holdBufNext = holdBuf;
        instrNext   = ifid_instr;
        pcPlus4Next = ifid_pc_plus4;
        validNext   = ifid_valid;

        case (state)
            BOOT: begin
                faNext    = pc;
                stateNext = FETCH;
            end

            FETCH: begin
                if (branch_taken) begin
                    pcNext    = target;
                    instrNext = '0;
                    validNext = 1'b0;
                    if (imem_ready) begin
                        // Data for the old path is dropped; start the target right away.
                        faNext = target;
                    end else begin
                        // Request cannot be aborted, so wait it out with fa untouched.
                        stateNext = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (adv) begin
                        instrNext   = imem_rdata;
                        pcPlus4Next = faPlus4;
                        validNext   = 1'b1;
                        pcNext      = faPlus4;
                        faNext      = faPlus4;
                    end else begin
                        holdBufNext = imem_rdata;
                        stateNext   = HOLD;
                    end
                end else if (adv) begin
                    instrNext = '0;
                    validNext = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    pcNext    = target;
                    faNext    = target;
                    instrNext = '0;
                    validNext = 1'b0;
                    stateNext = FETCH;
                end else if (adv) begin
                    instrNext   = holdBuf;
                    pcPlus4Next = faPlus4;
                    validNext   = 1'b1;
                    pcNext      = faPlus4;
                    faNext      = faPlus4;
                    stateNext   = FETCH;
                end
            end

            DRAIN: begin
                if (branch_taken) begin
                    pcNext = target;
                end
                if (adv || branch_taken) begin
                    instrNext = '0;
                    validNext = 1'b0;
                end
                if (imem_ready) begin
                    faNext    = branch_taken ? target : pc;
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    // State, PC, fetch address, stall buffer and IF/ID register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            fa            <= RESET_PC;
            holdBuf       <= '0;
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            fa            <= faNext;
            holdBuf       <= holdBufNext;
            ifid_instr    <= instrNext;
            ifid_pc_plus4 <= pcPlus4Next;
            ifid_valid    <= validNext;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a transaction-level model
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_enable;
    logic        if_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_enable    (pc_enable),
        .if_enable    (if_enable),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_valid   (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: architectural next PC, one request slot (active / wanted),
    // a queue holding at most one parked instruction, and the expected IF/ID.
    logic [31:0] mPc;
    logic        mBooted;
    logic        mReqActive;
    logic        mWanted;
    logic [31:0] mReqAddr;
    logic [31:0] bufInstrQ[$];
    logic [31:0] bufAddrQ[$];
    logic [31:0] eInstr;
    logic [31:0] ePc4;
    logic        eValid;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        eInstr = '0;
        eValid = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] instr, input logic [31:0] fromAddr);
        eInstr = instr;
        ePc4   = fromAddr + 32'd4;
        eValid = 1'b1;
        mPc    = fromAddr + 32'd4;
    endtask

    task automatic modelUpdate(input bit rstn, input bit pcEn, input bit ifEn, input bit br,
                               input logic [31:0] tgt, input bit rdy, input logic [31:0] rdata);
        bit adv;
        logic [31:0] t;
        adv = pcEn & ifEn;
        t = {tgt[31:2], 2'b00};
        if (!rstn) begin
            mPc = 32'h0; mBooted = 0; mReqActive = 0; mWanted = 0; mReqAddr = 32'h0;
            bufInstrQ.delete(); bufAddrQ.delete();
            eInstr = '0; ePc4 = '0; eValid = 0;
        end else if (!mBooted) begin
            mBooted = 1; mReqActive = 1; mWanted = 1; mReqAddr = mPc;
        end else if (mReqActive && mWanted) begin
            if (br) begin
                mPc = t;
                bubble();
                if (rdy) mReqAddr = t;
                else mWanted = 0;
            end else if (rdy) begin
                if (adv) begin
                    deliver(rdata, mReqAddr);
                    mReqAddr = mPc;
                end else begin
                    bufInstrQ.push_back(rdata);
                    bufAddrQ.push_back(mReqAddr);
                    mReqActive = 0;
                end
            end else if (adv) begin
                bubble();
            end
        end else if (mReqActive) begin
            if (br) mPc = t;
            if (adv || br) bubble();
            if (rdy) begin
                mReqAddr = mPc;
                mWanted = 1;
            end
        end else begin
            if (br) begin
                bufInstrQ.delete(); bufAddrQ.delete();
                mPc = t; mReqAddr = t; mReqActive = 1; mWanted = 1;
                bubble();
            end else if (adv) begin
                deliver(bufInstrQ.pop_front(), bufAddrQ.pop_front());
                mReqAddr = mPc;
                mReqActive = 1;
            end
        end
    endtask

    task automatic compareAll();
        check("imem_req", 64'(imem_req), 64'(mReqActive));
        if (mReqActive) check("imem_addr", 64'(imem_addr), 64'(mReqAddr));
        check("ifid_valid", 64'(ifid_valid), 64'(eValid));
        check("ifid_instr", 64'(ifid_instr), 64'(eInstr));
        if (eValid) check("ifid_pc_plus4", 64'(ifid_pc_plus4), 64'(ePc4));
    endtask

    // Inputs change at the falling edge; the model advances at the rising edge; outputs checked at the next falling edge.
    task automatic step(input bit rstn, input bit pcEn, input bit ifEn, input bit br,
                        input logic [31:0] tgt, input bit rdy);
        logic [31:0] rd;
        rd = rdy ? memWord(mReqAddr) : $urandom;
        rst_n = rstn; pc_enable = pcEn; if_enable = ifEn;
        branch_taken = br; branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
        @(posedge clk);
        modelUpdate(rstn, pcEn, ifEn, br, tgt, rdy, rd);
        @(negedge clk);
        compareAll();
    endtask

    initial begin
        logic [31:0] a0;
        bit r, pe, ie, b, rdy;
        rst_n = 0; pc_enable = 0; if_enable = 0; branch_taken = 0;
        branch_target = 0; imem_ready = 0; imem_rdata = 0;
        mPc = 0; mBooted = 0; mReqActive = 0; mWanted = 0; mReqAddr = 0;
        eInstr = 0; ePc4 = 0; eValid = 0;
        @(negedge clk);

        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        check("reset_req", 64'(imem_req), 64'd0);
        check("reset_valid", 64'(ifid_valid), 64'd0);
        check("reset_instr", 64'(ifid_instr), 64'd0);
        check("reset_pc4", 64'(ifid_pc_plus4), 64'd0);

        // Zero-wait streaming from 0.
        step(1, 1, 1, 0, 0, 0);
        check("boot_addr", 64'(imem_addr), 64'h0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 1);
        check("stream_addr_10", 64'(imem_addr), 64'h10);
        check("stream_pc4_c", 64'(ifid_pc_plus4), 64'h10);

        // Stall while the fetch of 0x10 completes.
        step(1, 0, 0, 0, 0, 1);
        check("stall_req_drop", 64'(imem_req), 64'd0);
        check("stall_hold_pc4", 64'(ifid_pc_plus4), 64'h10);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        check("release_instr", 64'(ifid_instr), 64'(memWord(32'h10)));
        check("release_pc4", 64'(ifid_pc_plus4), 64'h14);
        check("release_addr", 64'(imem_addr), 64'h14);

        // Branch with zero-wait memory at 0x20.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1);
        check("pre_branch_addr", 64'(imem_addr), 64'h20);
        step(1, 1, 1, 1, 32'h103, 1);
        check("branch_addr", 64'(imem_addr), 64'h100);
        check("branch_bubble_valid", 64'(ifid_valid), 64'd0);
        check("branch_bubble_instr", 64'(ifid_instr), 64'd0);
        step(1, 1, 1, 0, 0, 1);

        // Branch during a wait state: old address held until ready.
        a0 = mReqAddr;
        step(1, 1, 1, 1, 32'h200, 0);
        check("drain_addr_held", 64'(imem_addr), 64'(a0));
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1);
        check("drain_new_addr", 64'(imem_addr), 64'h200);
        check("drain_bubble", 64'(ifid_valid), 64'd0);

        // Branch while holding a parked instruction with if_enable low.
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 1, 32'h300, 0);
        check("hold_flush_valid", 64'(ifid_valid), 64'd0);
        check("hold_flush_addr", 64'(imem_addr), 64'h300);
        step(1, 1, 1, 0, 0, 1);
        check("hold_flush_deliver", 64'(ifid_instr), 64'(memWord(32'h300)));

        // Reset while draining.
        step(1, 1, 1, 1, 32'h400, 0);
        step(0, 1, 1, 0, 0, 0);
        check("drain_reset_req", 64'(imem_req), 64'd0);
        check("drain_reset_valid", 64'(ifid_valid), 64'd0);
        check("drain_reset_pc4", 64'(ifid_pc_plus4), 64'd0);
        step(1, 1, 1, 0, 0, 0);
        check("restart_addr", 64'(imem_addr), 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom % 80) != 0;
            pe  = ($urandom % 4) != 0;
            ie  = ($urandom % 4) != 0;
            b   = ($urandom % 8) == 0;
            rdy = mReqActive ? 1'($urandom % 2) : 1'b0;
            step(r, pe, ie, b, $urandom, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
